// File: rtl/uart_pkg.sv
// Shared encodings for the UART TX arbiter: FSM states, channel ids and the
// bit-7 stream tag that the RX demux also keys on.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWN0  = 3'd1,
    ST_OWN1  = 3'd2,
    ST_HOLD0 = 3'd3,
    ST_HOLD1 = 3'd4
  } arb_state_e;

  localparam logic CH_PROT  = 1'b0;
  localparam logic CH_SLAVE = 1'b1;

  localparam int unsigned TAG_BIT = 7;

  function automatic arb_state_e own_st(input logic ch);
    return ch ? ST_OWN1 : ST_OWN0;
  endfunction

  function automatic arb_state_e hold_st(input logic ch);
    return ch ? ST_HOLD1 : ST_HOLD0;
  endfunction

  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      ST_OWN0, ST_HOLD0: return 2'b01;
      ST_OWN1, ST_HOLD1: return 2'b10;
      default:           return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-bounded sharing of one uart_tx between the protocol
// response stream (ch0) and the bus-slave TX FIFO stream (ch1).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter bit          TAG_CH0   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_ch0_dat,
  input  logic       i_ch0_valid,
  output logic       o_ch0_ready,
  input  logic [7:0] i_ch1_dat,
  input  logic       i_ch1_valid,
  output logic       o_ch1_ready,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_start,
  input  logic       i_tx_ready,
  output logic [1:0] o_grant
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic [1:0] grant_q;

  logic       own_ch;
  logic       own_v;
  logic       oth_v;
  logic       in_own;
  logic       xfer;
  logic       sw;
  logic       sw_ch;
  logic [7:0] ch0_tagged;

  // Tie goes to the channel not served last; a lone requester always wins.
  function automatic logic pick(input logic last, input logic v0, input logic v1);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always_comb begin
    own_ch = (state_q == ST_OWN1) || (state_q == ST_HOLD1);
    in_own = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    own_v  = own_ch ? i_ch1_valid : i_ch0_valid;
    oth_v  = own_ch ? i_ch0_valid : i_ch1_valid;
    xfer   = in_own && own_v && i_tx_ready;
  end

  always_comb begin
    ch0_tagged          = i_ch0_dat;
    ch0_tagged[TAG_BIT] = i_ch0_dat[TAG_BIT] | TAG_CH0;
  end

  assign o_ch0_ready = (state_q == ST_OWN0) && i_tx_ready;
  assign o_ch1_ready = (state_q == ST_OWN1) && i_tx_ready;
  assign o_tx_start  = xfer;
  assign o_tx_dat    = (state_q == ST_IDLE) ? 8'h00 :
                       own_ch               ? i_ch1_dat : ch0_tagged;
  assign o_grant     = grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    sw      = 1'b0;
    sw_ch   = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_ch0_valid || i_ch1_valid) begin
          sw    = 1'b1;
          sw_ch = pick(last_q, i_ch0_valid, i_ch1_valid);
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (xfer) begin
          state_d = hold_st(own_ch);
          // Saturate so a lone streamer never wraps back into a fresh burst.
          if (burst_q != BURST_MAX) burst_d = burst_q + 4'd1;
        end else if (!own_v) begin
          if (oth_v) begin
            sw    = 1'b1;
            sw_ch = ~own_ch;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD0, ST_HOLD1: begin
        if ((burst_q == BURST_MAX) && oth_v) begin
          sw    = 1'b1;
          sw_ch = ~own_ch;
        end else if (own_v) begin
          state_d = own_st(own_ch);
        end else if (oth_v) begin
          sw    = 1'b1;
          sw_ch = ~own_ch;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sw) begin
      state_d = own_st(sw_ch);
      last_d  = sw_ch;
      burst_d = '0;
    end
  end

  // last resets to ch1 so ch0 wins the first tie out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      last_q  <= CH_SLAVE;
      burst_q <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      grant_q <= grant_of(state_d);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded random + directed bench for uart_tx_arbiter with a simple
// behavioural uart_tx model and per-channel byte queues.
module tb_uart_tx_arbiter;

  localparam int MAXB = 4;
  localparam bit TAG  = 1'b1;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] ch0_dat, ch1_dat, tx_dat;
  logic       ch0_v, ch1_v, ch0_r, ch1_r;
  logic       tx_start, tx_ready;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.MAX_BURST(MAXB), .TAG_CH0(TAG)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_ch0_dat(ch0_dat), .i_ch0_valid(ch0_v), .o_ch0_ready(ch0_r),
    .i_ch1_dat(ch1_dat), .i_ch1_valid(ch1_v), .o_ch1_ready(ch1_r),
    .o_tx_dat(tx_dat), .o_tx_start(tx_start), .i_tx_ready(tx_ready),
    .o_grant(grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];
  int  start_log[$];
  bit  en0, en1, ser_auto, ser_busy;
  int  ser_cnt;
  bit  start_seen, fire0_seen, fire1_seen;
  int  run_ch, run_cnt;
  bit  run_cont;
  int  start_cnt0, start_cnt1;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    if (ch == 0) begin
      src0_q.push_back(b);
      exp0_q.push_back(b | (TAG ? 8'h80 : 8'h00));
    end else begin
      src1_q.push_back(b);
      exp1_q.push_back(b);
    end
  endtask

  task automatic drive();
    ch0_v = en0 && (src0_q.size() > 0);
    ch1_v = en1 && (src1_q.size() > 0);
    if (ch0_v) ch0_dat = src0_q[0]; else ch0_dat = 8'($urandom);
    if (ch1_v) ch1_dat = src1_q[0]; else ch1_dat = 8'($urandom);
  endtask

  // Advance one cycle: retire consumed bytes, step the serializer model, redrive.
  task automatic tick();
    logic [7:0] junk;
    @(posedge clk);
    #1;
    if (fire0_seen) junk = src0_q.pop_front();
    if (fire1_seen) junk = src1_q.pop_front();
    if (ser_auto) begin
      if (start_seen) begin
        ser_busy = 1'b1;
        ser_cnt  = $urandom_range(1, 6);
        tx_ready = 1'($urandom_range(0, 1));
      end else if (ser_busy) begin
        if (ser_cnt > 0) begin
          ser_cnt--;
          tx_ready = 1'b0;
        end else begin
          ser_busy = 1'b0;
          tx_ready = 1'b1;
        end
      end else begin
        tx_ready = 1'b1;
      end
    end
    drive();
  endtask

  task automatic set_manual(input logic r);
    ser_auto = 1'b0;
    ser_busy = 1'b0;
    ser_cnt  = 0;
    tx_ready = r;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic drain(input string name);
    en0 = 1'b1;
    en1 = 1'b1;
    ser_auto = 1'b1;
    drive();
    for (int n = 0; n < 2000 && (src0_q.size() + src1_q.size()) > 0; n++) tick();
    tick();
    chk({name, "_drain"},
        (src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()) == 0,
        src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size(), 0);
  endtask

  // Monitor / scoreboard: every start must match the head of the owner's queue.
  always @(negedge clk) begin
    int ch;
    logic [7:0] want;
    start_seen = tx_start;
    fire0_seen = ch0_v && ch0_r;
    fire1_seen = ch1_v && ch1_r;
    chk("excl_ready", !(ch0_r && ch1_r), {ch1_r, ch0_r}, 0);
    if (i_reset) run_cont = 1'b0;
    if (run_cont && !(run_ch == 1 ? ch0_v : ch1_v)) run_cont = 1'b0;
    if (tx_start || fire0_seen || fire1_seen)
      chk("start_fire", tx_start && ({fire1_seen, fire0_seen} == grant),
          {tx_start, fire1_seen, fire0_seen}, {1'b1, grant});
    if (tx_start) begin
      ch = grant[1] ? 1 : 0;
      chk("start_ready", tx_ready && !ser_busy, {ser_busy, tx_ready}, 1);
      chk("start_grant", (grant == 2'b01) || (grant == 2'b10), grant, 1);
      if (ch == 0) begin
        if (exp0_q.size() == 0) chk("sb_ch0_unexpected", 1'b0, tx_dat, -1);
        else begin
          want = exp0_q.pop_front();
          chk("sb_ch0_data", tx_dat == want, tx_dat, want);
        end
        start_cnt0++;
      end else begin
        if (exp1_q.size() == 0) chk("sb_ch1_unexpected", 1'b0, tx_dat, -1);
        else begin
          want = exp1_q.pop_front();
          chk("sb_ch1_data", tx_dat == want, tx_dat, want);
        end
        start_cnt1++;
      end
      start_log.push_back(ch);
      // Consecutive bytes from one channel while the other waits continuously.
      if (run_cont && ch == run_ch) run_cnt++;
      else begin
        run_ch  = ch;
        run_cnt = 1;
      end
      run_cont = (ch == 1) ? ch0_v : ch1_v;
      if (run_cont) chk("burst_bound", run_cnt <= MAXB, run_cnt, MAXB);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, zeros, viol;
    i_reset = 1'b1; en0 = 0; en1 = 0; ser_auto = 1'b1; ser_busy = 0; ser_cnt = 0;
    tx_ready = 1'b1; run_cont = 0; run_ch = 0; run_cnt = 0;
    start_cnt0 = 0; start_cnt1 = 0;
    drive();
    tick();
    tick();

    // Reset state with both channels requesting, then the first tie.
    for (int i = 0; i < 12; i++) begin
      push(0, 8'(8'h10 + i));
      push(1, 8'(8'hA0 + i));
    end
    en0 = 1; en1 = 1;
    drive();
    tick();
    chk("rst_grant", grant == 2'b00, grant, 0);
    chk("rst_start", tx_start == 1'b0, tx_start, 0);
    chk("rst_ready", {ch1_r, ch0_r} == 2'b00, {ch1_r, ch0_r}, 0);
    chk("rst_dat", tx_dat == 8'h00, tx_dat, 0);
    start_log.delete();
    i_reset = 1'b0;
    tick();
    chk("lat_grant", grant == 2'b01, grant, 1);
    chk("lat_start", tx_start == 1'b1, tx_start, 1);
    for (int n = 0; n < 400 && start_log.size() < 9; n++) tick();
    chk("tie_count", start_log.size() >= 9, start_log.size(), 9);
    for (int k = 0; k < 9 && k < start_log.size(); k++)
      chk("tie_order", start_log[k] == (k / MAXB) % 2, start_log[k], (k / MAXB) % 2);
    drain("tie");

    // Single channel, tagged.
    do_reset();
    start_cnt0 = 0;
    push(0, 8'h41);
    push(0, 8'h42);
    en0 = 1;
    drive();
    for (int n = 0; n < 100 && src0_q.size() > 0; n++) tick();
    tick();
    chk("single_starts", start_cnt0 == 2, start_cnt0, 2);

    // Lone streamer, then the other channel arrives during HOLD.
    do_reset();
    for (int i = 0; i < 24; i++) push(1, 8'(i));
    en1 = 1;
    drive();
    start_log.delete();
    for (int n = 0; n < 1000 && start_log.size() < 20; n++) tick();
    zeros = 0;
    foreach (start_log[i]) if (start_log[i] == 0) zeros++;
    chk("lone_count", start_log.size() >= 20, start_log.size(), 20);
    chk("lone_owner", zeros == 0, zeros, 0);
    chk("lone_grant", grant == 2'b10, grant, 2);
    for (int n = 0; n < 100 && !start_seen; n++) tick();
    chk("lone_hold", start_seen == 1'b1, start_seen, 1);
    n1 = start_log.size();
    push(0, 8'h5A);
    en0 = 1;
    drive();
    for (int n = 0; n < 100 && start_log.size() <= n1; n++) tick();
    if (start_log.size() > n1) chk("lone_switch", start_log[n1] == 0, start_log[n1], 0);
    else chk("lone_switch_timeout", 1'b0, start_log.size(), n1 + 1);
    drain("lone");

    // Owner drops valid while the other requests.
    do_reset();
    set_manual(1'b0);
    push(0, 8'h11);
    push(1, 8'h22);
    en0 = 1; en1 = 0;
    drive();
    tick();
    chk("drop_own0", grant == 2'b01, grant, 1);
    en0 = 0; en1 = 1;
    drive();
    tick();
    chk("drop_own1", grant == 2'b10, grant, 2);
    drain("drop");

    // Serializer stall.
    do_reset();
    set_manual(1'b0);
    for (int i = 0; i < 3; i++) begin
      push(0, 8'(8'h60 + i));
      push(1, 8'(8'h70 + i));
    end
    en0 = 1; en1 = 1;
    drive();
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (tx_start || ch0_r || ch1_r) viol++;
    end
    chk("stall_quiet", viol == 0, viol, 0);
    tx_ready = 1'b1;
    drive();
    #1;
    chk("stall_release", tx_start == 1'b1, tx_start, 1);
    chk("stall_grant", grant == 2'b01, grant, 1);
    drain("stall");

    // Reset while in HOLD1.
    do_reset();
    for (int i = 0; i < 3; i++) push(1, 8'(8'hB0 + i));
    en1 = 1;
    drive();
    for (int n = 0; n < 100 && !start_seen; n++) tick();
    chk("hold1_reached", start_seen == 1'b1, start_seen, 1);
    i_reset = 1'b1;
    tick();
    chk("hold_rst_grant", grant == 2'b00, grant, 0);
    chk("hold_rst_start", tx_start == 1'b0, tx_start, 0);
    push(0, 8'h33);
    en0 = 1;
    i_reset = 1'b0;
    drive();
    tick();
    chk("hold_rst_tie", grant == 2'b01, grant, 1);
    drain("hold_rst");

    // Random traffic with valid drops and serializer jitter.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 2) == 0 && src0_q.size() < 8) push(0, 8'($urandom));
      if ($urandom_range(0, 2) == 0 && src1_q.size() < 8) push(1, 8'($urandom));
      en0 = ($urandom_range(0, 7) != 0);
      en1 = ($urandom_range(0, 7) != 0);
      tick();
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
